mips_fetch: RTL
===============

# mips_fetch

Instruction fetch stage for the MIPS core, directly upstream of the instruction decoder. Holds the program counter, issues one word read at a time to instruction memory over a valid/ready request channel, and buffers the returned word in a single-entry output register that the decoder drains over a valid/ready handshake. It accepts taken-branch redirects from the execute stage, flushing the buffered word and discarding any in-flight stale response.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  reset is asynchronous and active-low.
- `imem_req_valid`  out  1  read request to instruction memory.
- `imem_req_ready`  in  1  memory accepts request this cycle.
- `imem_req_addr`  out  32  byte address of request (= current PC).
- `imem_resp_valid`  in  1  read data valid; one pulse per accepted request, ≥1 cycle after acceptance; cannot be back-pressured.
- `imem_resp_data`  in  32  instruction word.
- `redirect_valid`  in  1  taken branch/jump; single-cycle pulse.
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored (forced 0).
- `inst_valid`  out  1  output register holds an instruction.
- `inst_ready`  in  1  decoder consumes the instruction this cycle.
- `instruction`  out  32  word presented to decode.
- `inst_pc`  out  32  address of `instruction`.
- `inst_pc_plus4`  out  32  `inst_pc` + 4, modulo 2^32.

## Operation
- State register: PC (32), FSM state, discard flag, output register {inst_valid, instruction, inst_pc}.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: entered only from reset; next cycle -> REQ.
  - REQ: `imem_req_valid` = 1 iff (!inst_valid || inst_ready) && !redirect_valid; `imem_req_addr` = PC. Handshake (valid && ready) -> WAIT.
  - WAIT: `imem_req_valid` = 0. On `imem_resp_valid`: if discard=1 or redirect_valid=1, drop data, clear discard, -> REQ; otherwise load output register {1, imem_resp_data, PC}, PC <= PC + 4, -> REQ.
- Request gating guarantees the output register is empty when a response lands; no overflow path exists.
- Output handshake: inst_valid && inst_ready clears inst_valid unless a response loads it the same cycle (then it reloads).
- Redirect (any state, priority over all else): PC <= {redirect_pc[31:2], 2'b00}; inst_valid <= 0; if in WAIT and no response this cycle, discard <= 1; FSM stays/returns in REQ unless in WAIT. In IDLE, redirect applies to PC and FSM still goes to REQ.
- A same-cycle inst_valid && inst_ready && redirect_valid counts as consumed by decode; buffer still cleared.
- PC increment wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- `imem_resp_valid` outside WAIT is ignored.

## Timing
- Reset values: PC = RESET_PC, state = IDLE, discard = 0, inst_valid = 0, instruction = 32'h0000_0000 (NOP), inst_pc = 0, imem_req_valid = 0 (combinational from IDLE), imem_req_addr = RESET_PC.
- Reset asserted mid-transaction: all state returns to reset values immediately; a response arriving after deassertion while in IDLE/REQ is ignored.
- First request: cycle after reset deassertion (REQ), addr = RESET_PC.
- Latency: request accepted cycle N, response cycle M ≥ N+1 -> inst_valid high cycle M+1; next request issued cycle M+1 if output drains or is empty.
- Peak throughput with zero-wait memory and inst_ready=1: one instruction per 2 cycles.
- Outputs `instruction`, `inst_pc`, `inst_pc_plus4`, `inst_valid` are registered; `imem_req_valid`/`imem_req_addr` depend combinationally on state, inst_valid, inst_ready, redirect_valid only.
- Redirect effect: first request to the new target issued the cycle after the redirect (or the cycle after the stale response is dropped if one was outstanding).

## Test plan
- Reset, RESET_PC=32'h0000_0040, memory returns addr-tagged words with 1-cycle latency, inst_ready=1 -> inst_pc sequence 0x40, 0x44, 0x48, each instruction matching its address, one per 2 cycles.
- Hold inst_ready=0 for 5 cycles after first instruction -> imem_req_valid stays 0, instruction/inst_pc stable; release -> next request to PC+4 the same cycle.
- Redirect to 32'h0000_1003 while WAIT with 3-cycle memory latency -> stale response dropped, inst_valid stays 0, next request addr 0x1000, next instruction inst_pc = 0x1000.
- Redirect on the same cycle as the response -> response dropped, no inst_valid pulse with the old PC.
- PC = 32'hFFFF_FFFC fetch -> inst_pc_plus4 = 0, next request addr 0.
- Assert rst_n low while WAIT, deassert, then pulse imem_resp_valid in IDLE -> ignored; first request addr = RESET_PC.

Source files
------------

// File: rtl/mips_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, execute redirect,
// and the decode-side instruction handshake.
interface mips_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr,
    output inst_valid, instruction, inst_pc, inst_pc_plus4,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  inst_valid, instruction, inst_pc, inst_pc_plus4,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/mips_fetch.sv
// MIPS instruction fetch: PC, one-outstanding imem read, single-entry output
// buffer toward decode, and branch redirect with stale-response discard.
module mips_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  mips_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic        discard;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] inst_pc_q;
  logic [31:0] plus4_q;

  logic        req_fire;
  logic        resp_take;
  logic        load;
  logic [31:0] redirect_target;

  assign req_fire        = bus.imem_req_valid && bus.imem_req_ready;
  assign resp_take       = (state == WAIT) && bus.imem_resp_valid;
  // A response is kept only if it was not made stale by an earlier or concurrent redirect.
  assign load            = resp_take && !discard && !bus.redirect_valid;
  assign redirect_target = bus.redirect_pc & ~32'h0000_0003;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = REQ;
      REQ:     if (req_fire) state_nxt = WAIT;
      WAIT:    if (bus.imem_resp_valid) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req_valid = (state == REQ) && (!valid_q || bus.inst_ready) && !bus.redirect_valid;
    bus.imem_req_addr  = pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      discard <= 1'b0;
    end else begin
      if (bus.redirect_valid) pc <= redirect_target;
      else if (load)          pc <= pc + 32'd4;

      if (resp_take)                                   discard <= 1'b0;
      else if (state == WAIT && bus.redirect_valid)    discard <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      instr_q   <= '0;
      inst_pc_q <= '0;
      plus4_q   <= 32'd4;
    end else begin
      if (bus.redirect_valid) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q   <= 1'b1;
        instr_q   <= bus.imem_resp_data;
        inst_pc_q <= pc;
        plus4_q   <= pc + 32'd4;
      end else if (valid_q && bus.inst_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.inst_valid    = valid_q;
  assign bus.instruction   = instr_q;
  assign bus.inst_pc       = inst_pc_q;
  assign bus.inst_pc_plus4 = plus4_q;

endmodule
